driver_addr_seq: RTL and testbench

//  Program sequencer between the address FIFO read port and the vector engine address input.

---
 rtl/driver_pkg.sv | 27 ++
 rtl/driver_addr_burst.sv | 48 ++++
 rtl/driver_addr_seq.sv | 165 ++++++++++++++++
 tb/tb_driver_addr_seq.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/driver_pkg.sv
// driver_pkg
//   Shared definitions for the driver address sequencer slice.
//   - ADDR_W_DEF / CNT_W_DEF / CONSEC_W_DEF : default widths
//   - addr_seq_state_t                      : sequencer state encoding
//   - sat_inc()                             : saturating increment for counters up to 32 bits
package driver_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned CONSEC_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_DONE
    } addr_seq_state_t;

    // Increments value, holding at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/driver_addr_burst.sv
// driver_addr_burst
//   Holds the address currently being issued and the number of burst
//   addresses still to follow it.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     load       : capture base into addr and len into the remaining count
//     step       : advance addr by one (wrapping) and consume one remaining
//     base       : base address to load
//     len        : extra addresses following the base
//     addr       : current address
//     last       : no further burst addresses remain
module driver_addr_burst
    import driver_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned CONSEC_W = CONSEC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [ADDR_W-1:0]   base,
    input  logic [CONSEC_W-1:0] len,
    output logic [ADDR_W-1:0]   addr,
    output logic                last
);

    logic [ADDR_W-1:0]   addr_r;
    logic [CONSEC_W-1:0] left_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r <= '0;
            left_r <= '0;
        end else if (load) begin
            addr_r <= base;
            left_r <= len;
        end else if (step) begin
            // Natural modulo-2^ADDR_W wrap from all-ones to zero.
            addr_r <= addr_r + ADDR_W'(1);
            left_r <= left_r - CONSEC_W'(1);
        end
    end

    assign addr = addr_r;
    assign last = (left_r == '0);

endmodule

// File: rtl/driver_addr_seq.sv
// driver_addr_seq
//   Program sequencer: pops base addresses from the address FIFO and issues
//   them (optionally expanded into bursts) to the vector engine.
//   Optional feature macro: ADDR_SEQ_UNDERRUN_EN adds output underrun_cnt.
//   Ports:
//     clk, reset          : clock, asynchronous active-high reset
//     run_program         : rising edge starts a program from IDLE
//     end_program         : graceful end request (finish burst, drain FIFO)
//     abort_program       : immediate stop, highest priority
//     freeze_addr_fifo    : inhibit FIFO pops
//     send_consec_addr    : enable burst expansion
//     consec_count        : extra addresses per base
//     addr_fifo_empty     : FIFO empty flag
//     addr_fifo_dout      : FIFO data, valid the cycle after addr_fifo_rd
//     addr_fifo_rd        : FIFO pop strobe
//     addr_ready          : downstream accept
//     addr_valid/addr_out : issued address handshake
//     active_program      : program in progress
//     prog_done           : one-cycle pulse on graceful completion
//     addr_cycle_cnt      : accepted addresses since last run start (saturating)
//     underrun_cnt        : (ADDR_SEQ_UNDERRUN_EN) FETCH cycles starved by empty FIFO
module driver_addr_seq
    import driver_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned CONSEC_W = CONSEC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_program,
    input  logic                end_program,
    input  logic                abort_program,
    input  logic                freeze_addr_fifo,
    input  logic                send_consec_addr,
    input  logic [CONSEC_W-1:0] consec_count,
    input  logic                addr_fifo_empty,
    input  logic [ADDR_W-1:0]   addr_fifo_dout,
    output logic                addr_fifo_rd,
    input  logic                addr_ready,
    output logic                addr_valid,
    output logic [ADDR_W-1:0]   addr_out,
    output logic                active_program,
    output logic                prog_done,
    output logic [CNT_W-1:0]    addr_cycle_cnt
`ifdef ADDR_SEQ_UNDERRUN_EN
    ,
    output logic [CNT_W-1:0]    underrun_cnt
`endif
);

    addr_seq_state_t state, state_nxt;

    logic             run_q;
    logic             end_pending;
    logic             run_start;
    logic             accept;
    logic             burst_load;
    logic             burst_step;
    logic             burst_last;
    logic [CNT_W-1:0] cycle_cnt_r;

    assign run_start = (state == ST_IDLE) & run_program & ~run_q & ~abort_program;

    always_comb begin
        state_nxt    = state;
        addr_fifo_rd = 1'b0;
        addr_valid   = 1'b0;
        prog_done    = 1'b0;
        burst_load   = 1'b0;
        burst_step   = 1'b0;
        accept       = 1'b0;
        if (abort_program) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (run_start) state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (!addr_fifo_empty && !freeze_addr_fifo) begin
                        addr_fifo_rd = 1'b1;
                        state_nxt    = ST_WAIT;
                    end else if (end_pending && addr_fifo_empty) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_WAIT: begin
                    burst_load = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
                ST_ISSUE: begin
                    addr_valid = 1'b1;
                    if (addr_ready) begin
                        accept = 1'b1;
                        if (send_consec_addr && !burst_last) burst_step = 1'b1;
                        else                                 state_nxt  = ST_FETCH;
                    end
                end
                ST_DONE: begin
                    prog_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign active_program = (state == ST_FETCH) | (state == ST_WAIT) | (state == ST_ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            // Treat run as already high out of reset so a level held through
            // reset is not seen as a rising edge.
            run_q       <= 1'b1;
            end_pending <= 1'b0;
            cycle_cnt_r <= '0;
        end else begin
            state <= state_nxt;
            run_q <= run_program;
            if (state == ST_IDLE)
                end_pending <= 1'b0;
            else if (active_program && end_program)
                end_pending <= 1'b1;
            if (run_start)
                cycle_cnt_r <= '0;
            else if (accept)
                cycle_cnt_r <= CNT_W'(sat_inc(32'(cycle_cnt_r), CNT_W));
        end
    end

    assign addr_cycle_cnt = cycle_cnt_r;

`ifdef ADDR_SEQ_UNDERRUN_EN
    logic [CNT_W-1:0] underrun_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_r <= '0;
        end else if (run_start) begin
            underrun_r <= '0;
        end else if ((state == ST_FETCH) && addr_fifo_empty && !end_pending && !freeze_addr_fifo) begin
            underrun_r <= CNT_W'(sat_inc(32'(underrun_r), CNT_W));
        end
    end

    assign underrun_cnt = underrun_r;
`endif

    driver_addr_burst #(
        .ADDR_W   (ADDR_W),
        .CONSEC_W (CONSEC_W)
    ) u_burst (
        .clk   (clk),
        .reset (reset),
        .load  (burst_load),
        .step  (burst_step),
        .base  (addr_fifo_dout),
        .len   (consec_count),
        .addr  (addr_out),
        .last  (burst_last)
    );

endmodule

// File: tb/tb_driver_addr_seq.sv
// tb_driver_addr_seq
//   Scoreboard bench for driver_addr_seq: expected addresses are queued as
//   FIFO words are pushed; a negedge monitor pops and compares on every
//   accepted handshake. Directed checks cover counters, flags and control.
module tb_driver_addr_seq;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned CONSEC_W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                run_program;
    logic                end_program;
    logic                abort_program;
    logic                freeze_addr_fifo;
    logic                send_consec_addr;
    logic [CONSEC_W-1:0] consec_count;
    logic                addr_fifo_empty;
    logic [ADDR_W-1:0]   addr_fifo_dout;
    logic                addr_fifo_rd;
    logic                addr_ready;
    logic                addr_valid;
    logic [ADDR_W-1:0]   addr_out;
    logic                active_program;
    logic                prog_done;
    logic [CNT_W-1:0]    addr_cycle_cnt;
`ifdef ADDR_SEQ_UNDERRUN_EN
    logic [CNT_W-1:0]    underrun_cnt;
`endif

    driver_addr_seq #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .CONSEC_W (CONSEC_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .run_program      (run_program),
        .end_program      (end_program),
        .abort_program    (abort_program),
        .freeze_addr_fifo (freeze_addr_fifo),
        .send_consec_addr (send_consec_addr),
        .consec_count     (consec_count),
        .addr_fifo_empty  (addr_fifo_empty),
        .addr_fifo_dout   (addr_fifo_dout),
        .addr_fifo_rd     (addr_fifo_rd),
        .addr_ready       (addr_ready),
        .addr_valid       (addr_valid),
        .addr_out         (addr_out),
        .active_program   (active_program),
        .prog_done        (prog_done),
        .addr_cycle_cnt   (addr_cycle_cnt)
`ifdef ADDR_SEQ_UNDERRUN_EN
        ,
        .underrun_cnt     (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_count = 0;
    int done_count = 0;
    int rd_count = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] fifo_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: data appears on dout the cycle after a pop.
    always @(posedge clk) begin
        if (addr_fifo_rd) begin
            rd_count++;
            chk("rd_not_empty", 64'(addr_fifo_empty), 64'(0));
            chk("rd_not_frozen", 64'(freeze_addr_fifo), 64'(0));
            if (fifo_q.size() != 0) addr_fifo_dout <= fifo_q.pop_front();
            addr_fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Monitor: compares each accepted address against the scoreboard.
    logic              stall_prev = 1'b0;
    logic [ADDR_W-1:0] held_addr = '0;

    always @(negedge clk) begin
        if (prog_done) done_count++;
        if (addr_valid && addr_ready) begin
            acc_count++;
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) chk("addr_out", 64'(addr_out), 64'(exp_q.pop_front()));
        end
        if (addr_valid && !addr_ready) begin
            if (stall_prev) chk("addr_stable", 64'(addr_out), 64'(held_addr));
            held_addr  = addr_out;
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] w);
        fifo_q.push_back(w);
        addr_fifo_empty = 1'b0;
    endtask

    task automatic wait_acc(input int target, input int limit, input string name);
        int n = 0;
        while (acc_count < target && n < limit) begin
            tick();
            n++;
        end
        chk(name, 64'(acc_count), 64'(target));
    endtask

    task automatic wait_done(input int target, input int limit, input string name);
        int n = 0;
        while (done_count < target && n < limit) begin
            tick();
            n++;
        end
        chk(name, 64'(done_count), 64'(target));
    endtask

    task automatic start_run();
        run_program = 1'b1;
        tick();
        run_program = 1'b0;
        chk("active_on_start", 64'(active_program), 64'(1));
        chk("cnt_cleared", 64'(addr_cycle_cnt), 64'(0));
    endtask

    task automatic end_and_wait(input string name);
        int d0 = done_count;
        end_program = 1'b1;
        tick();
        end_program = 1'b0;
        wait_done(d0 + 1, 20, name);
        chk({name, "_inactive"}, 64'(active_program), 64'(0));
        chk({name, "_single_pulse"}, 64'(prog_done), 64'(0));
    endtask

    initial begin
        int a0;
        int r0;
        int r1;
        int d0;
        int n;

        reset            = 1'b1;
        run_program      = 1'b1;
        end_program      = 1'b0;
        abort_program    = 1'b0;
        freeze_addr_fifo = 1'b0;
        send_consec_addr = 1'b0;
        consec_count     = '0;
        addr_fifo_empty  = 1'b1;
        addr_fifo_dout   = '0;
        addr_ready       = 1'b1;

        // Reset state, with run held high throughout
        tick();
        tick();
        chk("rst_valid", 64'(addr_valid), 64'(0));
        chk("rst_addr", 64'(addr_out), 64'(0));
        chk("rst_rd", 64'(addr_fifo_rd), 64'(0));
        chk("rst_active", 64'(active_program), 64'(0));
        chk("rst_done", 64'(prog_done), 64'(0));
        chk("rst_cnt", 64'(addr_cycle_cnt), 64'(0));
        reset = 1'b0;
        repeat (3) tick();
        chk("run_held_no_start", 64'(active_program), 64'(0));
        chk("run_held_no_rd", 64'(rd_count), 64'(0));
        run_program = 1'b0;
        tick();

        // Two plain words, then graceful end
        push(32'h100); exp_q.push_back(32'h100);
        push(32'h200); exp_q.push_back(32'h200);
        a0 = acc_count;
        start_run();
        tick();
        chk("latency_wait", 64'(addr_valid), 64'(0));
        tick();
        chk("latency_issue", 64'(addr_valid), 64'(1));
        wait_acc(a0 + 2, 20, "two_words");
        end_and_wait("end_prog1");
        chk("cnt_prog1", 64'(addr_cycle_cnt), 64'(2));

        // Burst of four, burst across wrap, ready stall
        start_run();
        a0 = acc_count;
        send_consec_addr = 1'b1;
        consec_count = 8'd3;
        push(32'h1000);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h1000 + 32'(i));
        wait_acc(a0 + 4, 30, "burst4");
        chk("burst4_back_fetch", 64'(addr_valid), 64'(0));
        chk("burst4_active", 64'(active_program), 64'(1));
        chk("burst4_cnt", 64'(addr_cycle_cnt), 64'(4));

        consec_count = 8'd2;
        push(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        wait_acc(a0 + 7, 30, "wrap_burst");

        addr_ready = 1'b0;
        consec_count = 8'd0;
        push(32'h5000); exp_q.push_back(32'h5000);
        n = 0;
        while (!addr_valid && n < 10) begin
            tick();
            n++;
        end
        chk("stall_valid", 64'(addr_valid), 64'(1));
        repeat (5) tick();
        chk("stall_no_accept", 64'(acc_count), 64'(a0 + 7));
        chk("stall_cnt", 64'(addr_cycle_cnt), 64'(7));
        addr_ready = 1'b1;
        wait_acc(a0 + 8, 10, "stall_release");
        chk("stall_cnt_after", 64'(addr_cycle_cnt), 64'(8));
        end_and_wait("end_prog2");

        // Freeze during a four-word program
        freeze_addr_fifo = 1'b1;
        consec_count = 8'd1;
        for (int i = 1; i <= 4; i++) begin
            push(32'(i) << 4);
            exp_q.push_back(32'(i) << 4);
            exp_q.push_back((32'(i) << 4) + 32'd1);
        end
        a0 = acc_count;
        start_run();
        r0 = rd_count;
        repeat (5) tick();
        chk("frozen_no_rd", 64'(rd_count), 64'(r0));
        chk("frozen_no_valid", 64'(addr_valid), 64'(0));
        freeze_addr_fifo = 1'b0;
        wait_acc(a0 + 1, 20, "unfreeze_first");
        freeze_addr_fifo = 1'b1;
        wait_acc(a0 + 2, 10, "burst_completes_frozen");
        r1 = rd_count;
        repeat (5) tick();
        chk("refrozen_no_rd", 64'(rd_count), 64'(r1));
        chk("refrozen_no_accept", 64'(acc_count), 64'(a0 + 2));
        freeze_addr_fifo = 1'b0;
        wait_acc(a0 + 8, 60, "freeze_resume");
        chk("freeze_fifo_drained", 64'(fifo_q.size()), 64'(0));
        end_and_wait("end_prog3");
        chk("cnt_prog3", 64'(addr_cycle_cnt), 64'(8));

        // Abort mid-burst with ready low
        consec_count = 8'd3;
        push(32'h7000); exp_q.push_back(32'h7000);
        push(32'h8000);
        a0 = acc_count;
        start_run();
        wait_acc(a0 + 1, 20, "abort_first");
        addr_ready = 1'b0;
        tick();
        tick();
        d0 = done_count;
        r0 = rd_count;
        abort_program = 1'b1;
        tick();
        abort_program = 1'b0;
        chk("abort_valid", 64'(addr_valid), 64'(0));
        chk("abort_active", 64'(active_program), 64'(0));
        repeat (5) tick();
        chk("abort_no_rd", 64'(rd_count), 64'(r0));
        chk("abort_no_done", 64'(done_count), 64'(d0));
        chk("abort_word_left", 64'(fifo_q.size()), 64'(1));
        fifo_q.delete();
        addr_fifo_empty = 1'b1;
        addr_ready = 1'b1;
        tick();

`ifdef ADDR_SEQ_UNDERRUN_EN
        // Starved FETCH cycles
        start_run();
        chk("underrun_cleared", 64'(underrun_cnt), 64'(0));
        repeat (10) tick();
        chk("underrun_10", 64'(underrun_cnt), 64'(10));
        abort_program = 1'b1;
        tick();
        abort_program = 1'b0;
        tick();
`endif

        // Asynchronous reset mid-burst
        consec_count = 8'd3;
        push(32'h9000); exp_q.push_back(32'h9000);
        a0 = acc_count;
        start_run();
        wait_acc(a0 + 1, 20, "reset_first");
        addr_ready = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(addr_valid), 64'(0));
        chk("async_rst_addr", 64'(addr_out), 64'(0));
        chk("async_rst_active", 64'(active_program), 64'(0));
        chk("async_rst_cnt", 64'(addr_cycle_cnt), 64'(0));
        chk("async_rst_rd", 64'(addr_fifo_rd), 64'(0));
        chk("async_rst_done", 64'(prog_done), 64'(0));
        tick();
        reset = 1'b0;
        addr_ready = 1'b1;
        tick();

        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
